// File: rtl/mac_rx_frame_pkg.sv
// Shared types and constants for the RMII receive MAC (mac_rx_frame) and its CRC engine.
package mac_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    HEADER,
    PAYLOAD,
    TAIL
  } state_t;

  localparam int          HDR_BYTES   = 14;
  localparam int          PRE_MIN     = 4;
  localparam logic [47:0] BROADCAST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [1:0]  SFD_DIBIT   = 2'b11;
  localparam logic [1:0]  PRE_DIBIT   = 2'b01;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/mac_rx_frame_if.sv
// RMII receive pins plus the parsed-frame result bus of mac_rx_frame.
interface mac_rx_frame_if #(
  parameter int PAYLOAD_BYTES = 4,
  parameter int CNT_W         = 16
);
  logic                       crsdv;
  logic [1:0]                 rxd;
  logic [15:0]                ethertype;
  logic [47:0]                src_mac;
  logic [8*PAYLOAD_BYTES-1:0] data;
  logic                       valid;
  logic                       drop;
  logic [CNT_W-1:0]           frames_ok;
  logic [CNT_W-1:0]           frames_bad;

  modport master (
    output crsdv, rxd,
    input  ethertype, src_mac, data, valid, drop, frames_ok, frames_bad
  );

  modport slave (
    input  crsdv, rxd,
    output ethertype, src_mac, data, valid, drop, frames_ok, frames_bad
  );
endinterface

// File: rtl/mac_rx_crc32.sv
// Reflected CRC-32 engine consuming one RMII dibit (LSB first) per enabled cycle.
// Only compiled when MAC_RX_FCS_CHECK_EN is defined.
`ifdef MAC_RX_FCS_CHECK_EN
module mac_rx_crc32
  import mac_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);
  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  logic [31:0] r_crc;

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    return (c[0] ^ b) ? ((c >> 1) ^ POLY_R) : (c >> 1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_crc <= '1;
    else if (clear) r_crc <= '1;
    else if (en)    r_crc <= crc_bit(crc_bit(r_crc, dibit[0]), dibit[1]);
  end

  assign crc = r_crc;
endmodule
`endif

// File: rtl/mac_rx_frame.sv
// RMII receive MAC: preamble/SFD hunt, header parse, payload capture, address/type filter.
// Optional FCS check enabled by defining MAC_RX_FCS_CHECK_EN.
module mac_rx_frame
  import mac_rx_pkg::*;
#(
  parameter int          PAYLOAD_BYTES   = 4,
  parameter logic [47:0] MAC_ADDR        = 48'h6969_5A06_5491,
  parameter logic [15:0] ETHERTYPE_MATCH = 16'h88B5,
  parameter int          CNT_W           = 16
) (
  input  logic         clk,
  input  logic         rst,
  mac_rx_frame_if.slave bus
);
  localparam int DW = 8 * PAYLOAD_BYTES;

  state_t           r_state, w_state_nx;
  logic [2:0]       r_pre_cnt;
  logic [1:0]       r_dibit_cnt;
  logic [5:0]       r_byte_cnt;
  logic [5:0]       r_byte;
  logic [47:0]      r_dst, r_src, r_src_out;
  logic [15:0]      r_type, r_type_out;
  logic [DW-1:0]    r_pay, r_data_out;
  logic             r_valid, r_drop;
  logic [CNT_W-1:0] r_ok, r_bad;

  logic       w_in_frame, w_end, w_shift, w_byte_done, w_sfd, w_accept, w_fcs_ok;
  logic [7:0] w_byte;

  assign w_in_frame  = (r_state == HEADER) || (r_state == PAYLOAD) || (r_state == TAIL);
  // End of frame only counts on a byte boundary; mid-byte CRS_DV drops are RMII toggling.
  assign w_end       = w_in_frame && (r_dibit_cnt == 2'd0) && !bus.crsdv;
  assign w_shift     = w_in_frame && !w_end;
  assign w_byte_done = w_shift && (r_dibit_cnt == 2'd3);
  assign w_byte      = {bus.rxd, r_byte};
  assign w_sfd       = (r_state == HUNT) && bus.crsdv && (bus.rxd == SFD_DIBIT) &&
                       (r_pre_cnt >= 3'(PRE_MIN));

`ifdef MAC_RX_FCS_CHECK_EN
  logic [31:0] w_crc;
  mac_rx_crc32 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (w_sfd),
    .en    (w_shift),
    .dibit (bus.rxd),
    .crc   (w_crc)
  );
  assign w_fcs_ok = (w_crc == CRC_RESIDUE);
`else
  assign w_fcs_ok = 1'b1;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_accept   = (r_state == TAIL) && w_fcs_ok &&
                 ((r_dst == MAC_ADDR) || (r_dst == BROADCAST)) &&
                 ((ETHERTYPE_MATCH == 16'h0000) || (r_type == ETHERTYPE_MATCH));
    case (r_state)
      IDLE:    if (!bus.crsdv) w_state_nx = HUNT;
      HUNT:    if (w_sfd) w_state_nx = HEADER;
      HEADER:  if (w_end) w_state_nx = IDLE;
               else if (w_byte_done && r_byte_cnt == 6'(HDR_BYTES - 1)) w_state_nx = PAYLOAD;
      PAYLOAD: if (w_end) w_state_nx = IDLE;
               else if (w_byte_done && r_byte_cnt == 6'(PAYLOAD_BYTES - 1)) w_state_nx = TAIL;
      TAIL:    if (w_end) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt   <= '0;
      r_dibit_cnt <= '0;
      r_byte_cnt  <= '0;
      r_byte      <= '0;
      r_dst       <= '0;
      r_src       <= '0;
      r_type      <= '0;
      r_pay       <= '0;
      r_valid     <= 1'b0;
      r_drop      <= 1'b0;
      r_src_out   <= '0;
      r_type_out  <= '0;
      r_data_out  <= '0;
      r_ok        <= '0;
      r_bad       <= '0;
    end else begin
      // Any non-preamble dibit in HUNT restarts the run; count saturates at PRE_MIN.
      if (r_state == HUNT && bus.crsdv && bus.rxd == PRE_DIBIT) begin
        if (r_pre_cnt < 3'(PRE_MIN)) r_pre_cnt <= r_pre_cnt + 3'd1;
      end else begin
        r_pre_cnt <= '0;
      end

      r_dibit_cnt <= w_shift ? r_dibit_cnt + 2'd1 : 2'd0;
      if (w_shift) r_byte <= w_byte[7:2];

      if (w_sfd) begin
        r_byte_cnt <= '0;
      end else if (w_byte_done && r_state != TAIL) begin
        r_byte_cnt <= (w_state_nx != r_state) ? 6'd0 : r_byte_cnt + 6'd1;
      end

      if (w_byte_done && r_state == HEADER) begin
        if (r_byte_cnt < 6'd6)       r_dst  <= {r_dst[39:0], w_byte};
        else if (r_byte_cnt < 6'd12) r_src  <= {r_src[39:0], w_byte};
        else                         r_type <= {r_type[7:0], w_byte};
      end
      if (w_byte_done && r_state == PAYLOAD) r_pay <= DW'({r_pay, w_byte});

      r_valid <= w_end && w_accept;
      r_drop  <= w_end && !w_accept;
      if (w_end && w_accept) begin
        r_src_out  <= r_src;
        r_type_out <= r_type;
        r_data_out <= r_pay;
        if (r_ok != '1) r_ok <= r_ok + 1'b1;
      end
      if (w_end && !w_accept && r_bad != '1) r_bad <= r_bad + 1'b1;
    end
  end

  assign bus.valid      = r_valid;
  assign bus.drop       = r_drop;
  assign bus.src_mac    = r_src_out;
  assign bus.ethertype  = r_type_out;
  assign bus.data       = r_data_out;
  assign bus.frames_ok  = r_ok;
  assign bus.frames_bad = r_bad;
endmodule
